t_1s: RTL and testbench



---
 rtl/t_1s.sv | 68 ++++++
 tb/tb_t_1s.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/t_1s.sv
// One-second tick generator: divides clk by CLK_HZ/TICK_HZ into a 1-cycle strobe,
// a 50% square wave and (with T_1S_SECCNT_EN defined) a wrapping 12-bit tick counter.
module t_1s #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    output logic        s,
    output logic        sq,
    output logic [11:0] sec_count
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_s;
    logic          r_sq;
    logic          w_tc;
    logic          w_tick;

    assign w_tc   = (r_cnt == LAST);
    // Same qualification as the strobe branch below, so the counter moves on the tick edge.
    assign w_tick = rst_n && !clr && en && w_tc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_s   <= 1'b0;
            r_sq  <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_s   <= 1'b0;
        end else if (!en) begin
            r_s   <= 1'b0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_s   <= 1'b1;
            r_sq  <= ~r_sq;
        end else begin
            r_cnt <= r_cnt + CW'(1);
            r_s   <= 1'b0;
        end
    end

`ifdef T_1S_SECCNT_EN
    logic [11:0] r_sec;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_sec <= 12'd0;
        else if (w_tick)
            r_sec <= r_sec + 12'd1;
    end

    assign sec_count = r_sec;
`else
    assign sec_count = 12'd0;
`endif

    assign s  = r_s;
    assign sq = r_sq;

endmodule

// File: tb/tb_t_1s.sv
// Directed bench for t_1s: per-cycle vector table (DIV=10) plus hand-written
// steady-run, wrap (DIV=2) and DIV=1 sequences.
module tb_t_1s;

`ifdef T_1S_SECCNT_EN
    localparam bit SEC_ON = 1'b1;
`else
    localparam bit SEC_ON = 1'b0;
`endif

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        clr;
        logic        s;
        logic        sq;
        logic [11:0] sec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, en, clr;
    logic        s, sq;
    logic [11:0] sec_count;

    logic        w_rst_n, w_en;
    logic        w_s, w_sq;
    logic [11:0] w_sec;
    logic        o_s, o_sq;
    logic [11:0] o_sec;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl [0:199];
    int   n_vec = 0;

    always #5 clk = ~clk;

    t_1s #(.CLK_HZ(10), .TICK_HZ(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .s(s), .sq(sq), .sec_count(sec_count));

    t_1s #(.CLK_HZ(2), .TICK_HZ(1)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .en(w_en), .clr(1'b0),
        .s(w_s), .sq(w_sq), .sec_count(w_sec));

    t_1s #(.CLK_HZ(1), .TICK_HZ(1)) u_one (
        .clk(clk), .rst_n(w_rst_n), .en(w_en), .clr(1'b0),
        .s(o_s), .sq(o_sq), .sec_count(o_sec));

    task automatic add(input logic r, input logic e, input logic c,
                       input logic xs, input logic xsq, input int xsec);
        tbl[n_vec] = '{r, e, c, xs, xsq, SEC_ON ? 12'(xsec) : 12'd0};
        n_vec++;
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c);
        rst_n = r; en = e; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses, spacing_bad, last_pulse, sq_toggles, sec_bad, one_bad;
        logic prev_sq;

        rst_n = 1'b0; en = 1'b1; clr = 1'b0;
        w_rst_n = 1'b0; w_en = 1'b0;

        // reset held 3 cycles, then first tick on the 10th enabled edge
        for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1);
        // en dropped for 7 cycles after the 4th enabled edge: tick 17 edges later
        for (int i = 0; i < 4; i++) add(1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 1, 1);
        add(1, 1, 0, 1, 0, 2);
        // clr on the terminal-count cycle suppresses that tick
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 0, 2);
        add(1, 1, 1, 0, 0, 2);
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 0, 2);
        add(1, 1, 0, 1, 1, 3);
        // reset on the terminal-count edge discards the pending tick
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 1, 3);
        add(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1);
        // en low while at terminal count holds the tick off
        for (int i = 0; i < 9; i++) add(1, 1, 0, 0, 1, 1);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 1, 0, 2);
        add(1, 1, 0, 0, 0, 2);

        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i].rst_n, tbl[i].en, tbl[i].clr);
            chk("s",   i, int'(s),         int'(tbl[i].s));
            chk("sq",  i, int'(sq),        int'(tbl[i].sq));
            chk("sec", i, int'(sec_count), int'(tbl[i].sec));
        end

        // steady run: 100 enabled cycles from reset
        step(0, 1, 0);
        step(0, 1, 0);
        pulses = 0; spacing_bad = 0; last_pulse = 0; sq_toggles = 0; sec_bad = 0;
        prev_sq = sq;
        for (int c = 1; c <= 100; c++) begin
            step(1, 1, 0);
            if (s) begin
                pulses++;
                if (c - last_pulse != 10) spacing_bad++;
                last_pulse = c;
            end
            if (sq != prev_sq) sq_toggles++;
            prev_sq = sq;
            if (int'(sec_count) != (SEC_ON ? pulses : 0)) sec_bad++;
        end
        chk("run_pulses",    100, pulses, 10);
        chk("run_spacing",   100, spacing_bad, 0);
        chk("run_sq_toggle", 100, sq_toggles, 10);
        chk("run_sq_final",  100, int'(sq), 0);
        chk("run_sec_track", 100, sec_bad, 0);
        chk("run_sec_final", 100, int'(sec_count), SEC_ON ? 10 : 0);

        // wrap with DIV=2; DIV=1 instance runs alongside and must tick every cycle
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("w_rst_sec", 0, int'(w_sec), 0);
        chk("one_rst_sq", 0, int'(o_sq), 0);
        w_rst_n = 1'b1; w_en = 1'b1;
        pulses = 0; one_bad = 0;
        prev_sq = o_sq;
        for (int c = 1; c <= 8192; c++) begin
            @(posedge clk); #1;
            if (w_s) pulses++;
            if (!o_s || o_sq == prev_sq) one_bad++;
            prev_sq = o_sq;
            if (c == 8191) chk("w_sec_4095", c, int'(w_sec), SEC_ON ? 4095 : 0);
        end
        chk("w_pulses",  8192, pulses, 4096);
        chk("w_sec_wrap", 8192, int'(w_sec), 0);
        chk("one_every_cycle", 8192, one_bad, 0);
        chk("one_sec", 8192, int'(o_sec), 0);
        w_en = 1'b0;
        prev_sq = o_sq;
        @(posedge clk); #1;
        chk("one_en0_s",  0, int'(o_s), 0);
        chk("one_en0_sq", 0, int'(o_sq), int'(prev_sq));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
